// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: op encoding,
// op field positions, response error codes and controller state encoding.
package mem_lsu_pkg;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  localparam int OP_STORE_BIT    = 3;
  localparam int OP_UNSIGNED_BIT = 2;
  localparam int OP_SIZE_LSB     = 0;
  localparam int OP_SIZE_W       = 2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_t;

  function automatic logic [1:0] opSize(input logic [3:0] op);
    return op[OP_SIZE_LSB +: OP_SIZE_W];
  endfunction

  // Stores are never unsigned and there is no unsigned word load.
  function automatic logic isLegalOp(input logic [3:0] op);
    logic [1:0] size;
    size = opSize(op);
    return (size != 2'b11)
        && !(op[OP_STORE_BIT] && op[OP_UNSIGNED_BIT])
        && !(op[OP_UNSIGNED_BIT] && (size == SIZE_WORD));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane extraction/extension for loads and lane merge for
// sub-word stores. Define LSU_BIG_ENDIAN_EN for big-endian lane mapping.
module lsu_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] memWord,
  input  logic [1:0]  byteOffset,
  input  logic [1:0]  size,
  input  logic        isUnsigned,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord
);

  logic [4:0]  laneShift;
  logic [31:0] laneMask;
  logic [31:0] shifted;

  always_comb begin
    laneShift = 5'd0;
    laneMask  = 32'hFFFF_FFFF;
    case (size)
      SIZE_BYTE: begin
`ifdef LSU_BIG_ENDIAN_EN
        laneShift = {~byteOffset, 3'b000};
`else
        laneShift = {byteOffset, 3'b000};
`endif
        laneMask = 32'h0000_00FF << laneShift;
      end
      SIZE_HALF: begin
`ifdef LSU_BIG_ENDIAN_EN
        laneShift = {~byteOffset[1], 4'b0000};
`else
        laneShift = {byteOffset[1], 4'b0000};
`endif
        laneMask = 32'h0000_FFFF << laneShift;
      end
      default: begin
        laneShift = 5'd0;
        laneMask  = 32'hFFFF_FFFF;
      end
    endcase

    shifted = memWord >> laneShift;

    case (size)
      SIZE_BYTE: loadData = isUnsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: loadData = isUnsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default:   loadData = shifted;
    endcase

    // Word size has a full mask and zero shift, so this degenerates to storeData.
    mergedWord = (memWord & ~laneMask) | ((storeData << laneShift) & laneMask);
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MIPS32 memory-stage load/store unit: byte-addressed requests to word memory
// accesses, read-modify-write for SB/SH. Define LSU_BIG_ENDIAN_EN for big-endian lanes.
module mem_stage_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DM_DEPTH = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [3:0]  ReqOp,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqData,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespData,
  output logic [1:0]  RespErr,
  output logic [31:0] DmAddr,
  output logic [31:0] DmDataIn,
  output logic        DmWriteEnable,
  output logic        DmReadEnable,
  input  logic [31:0] DmDataOut
);

  localparam logic [31:0] DM_DEPTH_W = 32'(DM_DEPTH);

  lsu_state_t  state;
  logic [3:0]  opQ;
  logic [1:0]  byteOffsetQ;
  logic [31:0] storeDataQ;
  logic        acceptReq;
  logic [1:0]  reqErr;
  logic [1:0]  reqSize;
  logic [31:0] loadData;
  logic [31:0] mergedWord;

  // Strobes and ready are masked by Reset so an in-flight access is dropped in the reset cycle.
  assign ReqReady      = (state == ST_IDLE)  && !Reset;
  assign DmReadEnable  = (state == ST_READ)  && !Reset;
  assign DmWriteEnable = (state == ST_WRITE) && !Reset;
  assign acceptReq     = ReqReady && ReqValid;
  assign reqSize       = opSize(ReqOp);

  always_comb begin
    reqErr = ERR_OK;
    if (!isLegalOp(ReqOp))
      reqErr = ERR_ILLEGAL;
    else if (((reqSize == SIZE_HALF) && ReqAddr[0]) ||
             ((reqSize == SIZE_WORD) && (ReqAddr[1:0] != 2'b00)))
      reqErr = ERR_MISALIGN;
    else if ({2'b00, ReqAddr[31:2]} >= DM_DEPTH_W)
      reqErr = ERR_RANGE;
  end

  lsu_lane_align uLaneAlign (
    .memWord    (DmDataOut),
    .byteOffset (byteOffsetQ),
    .size       (opSize(opQ)),
    .isUnsigned (opQ[OP_UNSIGNED_BIT]),
    .storeData  (storeDataQ),
    .loadData   (loadData),
    .mergedWord (mergedWord)
  );

  // Request capture: data only, no reset needed.
  always_ff @(posedge Clk) begin
    if (acceptReq) begin
      opQ         <= ReqOp;
      byteOffsetQ <= ReqAddr[1:0];
      storeDataQ  <= ReqData;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      RespValid <= 1'b0;
      RespData  <= 32'h0;
      RespErr   <= ERR_OK;
      DmAddr    <= 32'h0;
      DmDataIn  <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acceptReq) begin
            DmAddr   <= {2'b00, ReqAddr[31:2]};
            DmDataIn <= ReqData;
            RespData <= 32'h0;
            RespErr  <= reqErr;
            if (reqErr != ERR_OK) begin
              RespValid <= 1'b1;
              state     <= ST_RESP;
            end else if (ReqOp[OP_STORE_BIT] && (reqSize == SIZE_WORD)) begin
              state <= ST_WRITE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        // The merged store word is captured straight into DmDataIn for the WRITE cycle.
        ST_READ: begin
          if (opQ[OP_STORE_BIT]) begin
            DmDataIn <= mergedWord;
            state    <= ST_WRITE;
          end else begin
            RespData  <= loadData;
            RespValid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          RespValid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (RespReady) begin
            RespValid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu with a word-addressed memory model
// (default little-endian build).
module tb_mem_stage_lsu;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [3:0]  ReqOp;
  logic [31:0] ReqAddr;
  logic [31:0] ReqData;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] RespData;
  logic [1:0]  RespErr;
  logic [31:0] DmAddr;
  logic [31:0] DmDataIn;
  logic        DmWriteEnable;
  logic        DmReadEnable;
  logic [31:0] DmDataOut;

  logic [31:0] mem [0:1023];
  logic        clearMem;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    int          lat;
    int          rd;
    int          wr;
  } exp_t;

  exp_t sb[$];
  int   nChecks = 0;
  int   nPass   = 0;

  always #5 Clk = ~Clk;

  mem_stage_lsu #(.DM_DEPTH(1024)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ReqValid      (ReqValid),
    .ReqReady      (ReqReady),
    .ReqOp         (ReqOp),
    .ReqAddr       (ReqAddr),
    .ReqData       (ReqData),
    .RespValid     (RespValid),
    .RespReady     (RespReady),
    .RespData      (RespData),
    .RespErr       (RespErr),
    .DmAddr        (DmAddr),
    .DmDataIn      (DmDataIn),
    .DmWriteEnable (DmWriteEnable),
    .DmReadEnable  (DmReadEnable),
    .DmDataOut     (DmDataOut)
  );

  assign DmDataOut = (DmAddr < 32'd1024) ? mem[DmAddr[9:0]] : 32'h0;

  always @(posedge Clk) begin
    if (clearMem) begin
      foreach (mem[i]) mem[i] <= 32'h0;
    end else if (DmWriteEnable) begin
      mem[DmAddr[9:0]] <= DmDataIn;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Starts and ends at a negedge with the DUT idle.
  task automatic runReq(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] expData, input logic [1:0] expErr,
                        input int expLat, input int expRd, input int expWr, input int hold);
    exp_t e;
    int cyc, rd, wr;
    logic [31:0] held;
    e.data = expData; e.err = expErr; e.lat = expLat; e.rd = expRd; e.wr = expWr;
    sb.push_back(e);
    chk("reqReadyIdle", 32'(ReqReady), 32'd1);
    ReqOp = op; ReqAddr = addr; ReqData = data; ReqValid = 1'b1;
    @(posedge Clk);
    #1 ReqValid = 1'b0; ReqOp = 4'h0; ReqAddr = 32'h0; ReqData = 32'h0;
    cyc = 0; rd = -1; wr = -1;
    do begin
      @(negedge Clk);
      cyc++;
      if (DmReadEnable && rd < 0) rd = cyc;
      if (DmWriteEnable && wr < 0) wr = cyc;
      chk("enOverlap", 32'(DmReadEnable & DmWriteEnable), 32'd0);
      if (DmReadEnable || DmWriteEnable) chk("dmAddr", DmAddr, {2'b00, addr[31:2]});
    end while (!RespValid && cyc < 10);
    if (!RespValid) begin
      chk("respTimeout", 32'd0, 32'd1);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk("respData", RespData, e.data);
    chk("respErr", 32'(RespErr), 32'(e.err));
    chk("latency", 32'(cyc), 32'(e.lat));
    chk("readCycle", 32'(rd), 32'(e.rd));
    chk("writeCycle", 32'(wr), 32'(e.wr));
    held = RespData;
    repeat (hold) begin
      @(negedge Clk);
      chk("holdValid", 32'(RespValid), 32'd1);
      chk("holdData", RespData, held);
      chk("holdReqReady", 32'(ReqReady), 32'd0);
    end
    RespReady = 1'b1;
    @(posedge Clk);
    #1 RespReady = 1'b0;
    @(negedge Clk);
    chk("respDrop", 32'(RespValid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; clearMem = 1'b1;
    ReqValid = 1'b0; ReqOp = 4'h0; ReqAddr = 32'h0; ReqData = 32'h0; RespReady = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    clearMem = 1'b0;
    chk("rstReqReady", 32'(ReqReady), 32'd0);
    chk("rstRespValid", 32'(RespValid), 32'd0);
    chk("rstRespData", RespData, 32'h0);
    chk("rstRespErr", 32'(RespErr), 32'd0);
    chk("rstDmAddr", DmAddr, 32'h0);
    chk("rstDmDataIn", DmDataIn, 32'h0);
    chk("rstEnables", 32'({DmReadEnable, DmWriteEnable}), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // op, addr, data, expData, expErr, lat, rdCyc, wrCyc, hold
    runReq(4'b1010, 32'h30, 32'hDEADBEEF, 32'h0, 2'b00, 2, -1, 1, 0);
    chk("memWord12", mem[12], 32'hDEADBEEF);
    runReq(4'b0010, 32'h30, 32'h0, 32'hDEADBEEF, 2'b00, 2, 1, -1, 0);
    runReq(4'b0000, 32'h33, 32'h0, 32'hFFFFFFDE, 2'b00, 2, 1, -1, 0);
    runReq(4'b0100, 32'h33, 32'h0, 32'h000000DE, 2'b00, 2, 1, -1, 0);
    runReq(4'b0001, 32'h32, 32'h0, 32'hFFFFDEAD, 2'b00, 2, 1, -1, 0);
    runReq(4'b0101, 32'h30, 32'h0, 32'h0000BEEF, 2'b00, 2, 1, -1, 0);

    runReq(4'b1000, 32'h31, 32'hFFFFFF12, 32'h0, 2'b00, 3, 1, 2, 0);
    runReq(4'b0010, 32'h30, 32'h0, 32'hDEAD12EF, 2'b00, 2, 1, -1, 0);
    runReq(4'b1001, 32'h32, 32'hABCD1234, 32'h0, 2'b00, 3, 1, 2, 0);
    chk("memWord12Sh", mem[12], 32'h123412EF);
    runReq(4'b0101, 32'h32, 32'h0, 32'h00001234, 2'b00, 2, 1, -1, 0);
    runReq(4'b0000, 32'h30, 32'h0, 32'hFFFFFFEF, 2'b00, 2, 1, -1, 0);
    runReq(4'b0001, 32'h30, 32'h0, 32'h000012EF, 2'b00, 2, 1, -1, 0);
    runReq(4'b0100, 32'h31, 32'h0, 32'h00000012, 2'b00, 2, 1, -1, 0);

    runReq(4'b1010, 32'hFFC, 32'h80000001, 32'h0, 2'b00, 2, -1, 1, 0);
    runReq(4'b0000, 32'hFFF, 32'h0, 32'hFFFFFF80, 2'b00, 2, 1, -1, 0);
    runReq(4'b0100, 32'hFFC, 32'h0, 32'h00000001, 2'b00, 2, 1, -1, 0);

    runReq(4'b0010, 32'h32,   32'h0, 32'h0, 2'b01, 1, -1, -1, 0);
    runReq(4'b0001, 32'h31,   32'h0, 32'h0, 2'b01, 1, -1, -1, 0);
    runReq(4'b0010, 32'h1000, 32'h0, 32'h0, 2'b10, 1, -1, -1, 0);
    runReq(4'b1001, 32'h1002, 32'h0, 32'h0, 2'b10, 1, -1, -1, 0);
    runReq(4'b1010, 32'h1001, 32'h0, 32'h0, 2'b01, 1, -1, -1, 0);
    runReq(4'b0111, 32'h30,   32'h0, 32'h0, 2'b11, 1, -1, -1, 0);
    runReq(4'b0110, 32'h30,   32'h0, 32'h0, 2'b11, 1, -1, -1, 0);
    runReq(4'b1100, 32'h1003, 32'h0, 32'h0, 2'b11, 1, -1, -1, 0);

    runReq(4'b0010, 32'h30, 32'h0, 32'h123412EF, 2'b00, 2, 1, -1, 5);

    // Reset in the WRITE cycle of SW 0x40 must drop the write and the response.
    chk("abortReqReady", 32'(ReqReady), 32'd1);
    ReqOp = 4'b1010; ReqAddr = 32'h40; ReqData = 32'h55AA55AA; ReqValid = 1'b1;
    @(posedge Clk);
    #1 ReqValid = 1'b0;
    @(negedge Clk);
    chk("abortInWrite", 32'(DmWriteEnable), 32'd1);
    Reset = 1'b1;
    #1;
    chk("abortWeMasked", 32'(DmWriteEnable), 32'd0);
    chk("abortReqReady0", 32'(ReqReady), 32'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("abortMem16", mem[16], 32'h0);
    chk("abortRespValid", 32'(RespValid), 32'd0);
    chk("abortIdle", 32'(ReqReady), 32'd1);
    runReq(4'b0010, 32'h40, 32'h0, 32'h0, 2'b00, 2, 1, -1, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
